// File: rtl/memory_stage.sv
// Memory pipeline stage: owns the data memory, the stack and SP, and feeds the MEM/WB buffer.
// 32-bit PC pushes and pops take two cycles, with stall_out held only during the first one.
module memory_stage #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] result_in,
  input  logic [15:0] read_data1_in,
  input  logic [15:0] read_data2_in,
  input  logic [31:0] pc_plus_one_in,
  input  logic [2:0]  flag_register_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_push,
  input  logic        mem_pop,
  input  logic [1:0]  memory_address_select,
  input  logic [1:0]  memory_write_src_select,
  input  logic        pc_choose_memory,
  input  logic        reg_write,
  input  logic [1:0]  wb_sel,
  input  logic [2:0]  reg_write_address,
  input  logic        outport_enable,
  input  logic [15:0] LDM_value,
  input  logic [15:0] input_port,
  output logic        reg_write_out,
  output logic [1:0]  wb_sel_out,
  output logic [2:0]  reg_write_address_out,
  output logic        outport_enable_out,
  output logic [15:0] LDM_value_out,
  output logic [15:0] input_port_out,
  output logic [15:0] result_out,
  output logic [15:0] read_data1_out,
  output logic [15:0] mem_data_out,
  output logic [31:0] popped_pc_out,
  output logic        pc_load_out,
  output logic        stall_out
);

  typedef enum logic {IDLE, SECOND} state_t;

  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  state_t            state;
  logic [ADDR_W-1:0] sp;
  logic [15:0]       low_half;

  logic [ADDR_W-1:0] sp_inc, sp_dec, ls_addr, wr_addr, rd_addr;
  logic [15:0]       wr_data, rd_word;
  logic              do_push, do_pop, do_write, do_read;
  logic              wide_push, wide_pop, first_half, mem_we;

  always_comb begin
    do_push    = mem_push;
    do_pop     = !mem_push && mem_pop;
    do_write   = !mem_push && !mem_pop && mem_write;
    do_read    = !mem_push && !mem_pop && mem_read;
    wide_push  = do_push && (memory_write_src_select == 2'b10);
    wide_pop   = do_pop && pc_choose_memory;
    first_half = (state == IDLE) && (wide_push || wide_pop);
    stall_out  = first_half;

    sp_inc = sp + SP_ONE;
    sp_dec = sp - SP_ONE;

    case (memory_address_select)
      2'b00:   ls_addr = result_in[ADDR_W-1:0];
      2'b01:   ls_addr = read_data2_in[ADDR_W-1:0];
      default: ls_addr = sp;
    endcase

    // The high PC half goes out first so the low half ends up on top of the stack.
    case (memory_write_src_select)
      2'b00:   wr_data = read_data1_in;
      2'b01:   wr_data = read_data2_in;
      2'b10:   wr_data = first_half ? pc_plus_one_in[31:16] : pc_plus_one_in[15:0];
      default: wr_data = {13'b0, flag_register_in};
    endcase

    wr_addr = do_push ? sp : ls_addr;
    rd_addr = do_pop ? sp_inc : ls_addr;
    mem_we  = do_push || do_write;
    rd_word = mem[rd_addr];
  end

  // Memory array: no reset, writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // MEM/WB register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      sp                    <= SP_RESET;
      low_half              <= '0;
      reg_write_out         <= 1'b0;
      wb_sel_out            <= '0;
      reg_write_address_out <= '0;
      outport_enable_out    <= 1'b0;
      LDM_value_out         <= '0;
      input_port_out        <= '0;
      result_out            <= '0;
      read_data1_out        <= '0;
      mem_data_out          <= '0;
      popped_pc_out         <= '0;
      pc_load_out           <= 1'b0;
    end else begin
      state                 <= first_half ? SECOND : IDLE;
      reg_write_out         <= reg_write && !first_half;
      outport_enable_out    <= outport_enable && !first_half;
      wb_sel_out            <= wb_sel;
      reg_write_address_out <= reg_write_address;
      LDM_value_out         <= LDM_value;
      input_port_out        <= input_port;
      result_out            <= result_in;
      read_data1_out        <= read_data1_in;
      pc_load_out           <= 1'b0;

      if (do_push) begin
        sp <= sp_dec;
      end else if (do_pop) begin
        sp <= sp_inc;
        if (!wide_pop) begin
          mem_data_out <= rd_word;
        end else if (first_half) begin
          low_half <= rd_word;
        end else begin
          popped_pc_out <= {rd_word, low_half};
          pc_load_out   <= 1'b1;
        end
      end else if (do_read) begin
        mem_data_out <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver queues expected post-edge outputs,
// a monitor pops and compares them one edge later; popped PCs have their own queue.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] result_in, read_data1_in, read_data2_in, LDM_value, input_port;
  logic [31:0] pc_plus_one_in;
  logic [2:0]  flag_register_in, reg_write_address;
  logic        mem_read, mem_write, mem_push, mem_pop, pc_choose_memory;
  logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
  logic        reg_write, outport_enable;
  logic        reg_write_out, outport_enable_out, pc_load_out, stall_out;
  logic [1:0]  wb_sel_out;
  logic [2:0]  reg_write_address_out;
  logic [15:0] LDM_value_out, input_port_out, result_out, read_data1_out, mem_data_out;
  logic [31:0] popped_pc_out;

  memory_stage #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .result_in(result_in), .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
    .pc_plus_one_in(pc_plus_one_in), .flag_register_in(flag_register_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .pc_choose_memory(pc_choose_memory),
    .reg_write(reg_write), .wb_sel(wb_sel), .reg_write_address(reg_write_address),
    .outport_enable(outport_enable), .LDM_value(LDM_value), .input_port(input_port),
    .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
    .reg_write_address_out(reg_write_address_out), .outport_enable_out(outport_enable_out),
    .LDM_value_out(LDM_value_out), .input_port_out(input_port_out),
    .result_out(result_out), .read_data1_out(read_data1_out), .mem_data_out(mem_data_out),
    .popped_pc_out(popped_pc_out), .pc_load_out(pc_load_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          c_md;  logic [15:0] md;
    bit          c_rw;  logic        rw;
    bit          c_pl;  logic        pl;
    bit          c_sp;  logic [11:0] sp;
    bit          c_pt;  logic [69:0] pt;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] pcq[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t e0(input string nm);
    exp_t e;
    e.nm = nm;
    e.c_md = 0; e.md = '0; e.c_rw = 0; e.rw = 0; e.c_pl = 0; e.pl = 0;
    e.c_sp = 0; e.sp = '0; e.c_pt = 0; e.pt = '0;
    return e;
  endfunction

  task automatic idle();
    result_in = '0; read_data1_in = '0; read_data2_in = '0; pc_plus_one_in = '0;
    flag_register_in = '0; mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
    memory_address_select = '0; memory_write_src_select = '0; pc_choose_memory = 0;
    reg_write = 0; wb_sel = '0; reg_write_address = '0; outport_enable = 0;
    LDM_value = '0; input_port = '0;
  endtask

  // Queue the expectation for the coming edge and check the combinational stall now.
  task automatic go(input exp_t e, input bit c_st, input logic st);
    expq.push_back(e);
    #1;
    if (c_st) chk({e.nm, "_stall"}, 128'(stall_out), 128'(st));
  endtask

  task automatic check_reset_outs(input string nm);
    chk(nm, {8'h0, result_out, read_data1_out, mem_data_out, popped_pc_out, pc_load_out,
             reg_write_out, wb_sel_out, reg_write_address_out, outport_enable_out,
             LDM_value_out, input_port_out}, 128'h0);
    chk({nm, "_stall"}, 128'(stall_out), 128'h0);
    chk({nm, "_sp"}, 128'(dut.sp), 128'h0FFF);
  endtask

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset === 1'b1 && pc_load_out === 1'b1) begin
      if (pcq.size() == 0) begin
        chk("popped_pc_unexpected", 128'(popped_pc_out), 128'hFFFF_FFFF_FFFF);
      end else begin
        chk("popped_pc", 128'(popped_pc_out), 128'(pcq.pop_front()));
      end
    end
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.c_md) chk({e.nm, "_md"}, 128'(mem_data_out), 128'(e.md));
      if (e.c_rw) chk({e.nm, "_rw"}, 128'(reg_write_out), 128'(e.rw));
      if (e.c_pl) chk({e.nm, "_pcload"}, 128'(pc_load_out), 128'(e.pl));
      if (e.c_sp) chk({e.nm, "_sp"}, 128'(dut.sp), 128'(e.sp));
      if (e.c_pt) chk({e.nm, "_pt"},
                      128'({result_out, read_data1_out, LDM_value_out, input_port_out,
                            wb_sel_out, reg_write_address_out, outport_enable_out}),
                      128'(e.pt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic store(input string nm, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] md_hold);
    exp_t e;
    @(negedge clk); idle();
    mem_write = 1; result_in = a; read_data1_in = d;
    e = e0(nm); e.c_md = 1; e.md = md_hold;
    go(e, 1, 0);
  endtask

  task automatic load(input string nm, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    @(negedge clk); idle();
    mem_read = 1; result_in = a;
    e = e0(nm); e.c_md = 1; e.md = d;
    go(e, 0, 0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_init");
    reset = 1'b1;

    // Pass-through fields
    @(negedge clk); idle();
    result_in = 16'h1357; read_data1_in = 16'h2468; LDM_value = 16'h0ACE; input_port = 16'h0BDF;
    wb_sel = 2'b10; reg_write_address = 3'b101; outport_enable = 1; reg_write = 1;
    e = e0("passthru"); e.c_rw = 1; e.rw = 1; e.c_md = 1; e.md = 16'h0;
    e.c_pt = 1; e.pt = {16'h1357, 16'h2468, 16'h0ACE, 16'h0BDF, 2'b10, 3'b101, 1'b1};
    go(e, 1, 0);

    store("store_010", 16'h0010, 16'hBEEF, 16'h0000);
    load("load_010", 16'h0010, 16'hBEEF);
    @(negedge clk); idle();
    e = e0("idle_hold"); e.c_md = 1; e.md = 16'hBEEF; e.c_rw = 1; e.rw = 0;
    go(e, 1, 0);

    // Wide push of 0x0001_0023 from SP=0xFFF
    @(negedge clk); idle();
    mem_push = 1; memory_write_src_select = 2'b10; pc_plus_one_in = 32'h0001_0023; reg_write = 1;
    e = e0("wpush1"); e.c_rw = 1; e.rw = 0; e.c_sp = 1; e.sp = 12'hFFE; e.c_pl = 1; e.pl = 0;
    go(e, 1, 1);
    @(negedge clk);
    e = e0("wpush2"); e.c_rw = 1; e.rw = 1; e.c_sp = 1; e.sp = 12'hFFD;
    go(e, 1, 0);

    // Wide pop right after
    @(negedge clk); idle();
    mem_pop = 1; pc_choose_memory = 1; reg_write = 1;
    e = e0("wpop1"); e.c_rw = 1; e.rw = 0; e.c_sp = 1; e.sp = 12'hFFE; e.c_pl = 1; e.pl = 0;
    go(e, 1, 1);
    @(negedge clk);
    e = e0("wpop2"); e.c_rw = 1; e.rw = 1; e.c_sp = 1; e.sp = 12'hFFF; e.c_pl = 1; e.pl = 1;
    e.c_md = 1; e.md = 16'hBEEF;
    pcq.push_back(32'h0001_0023);
    go(e, 1, 0);
    @(negedge clk); idle();
    e = e0("after_wpop"); e.c_pl = 1; e.pl = 0;
    go(e, 0, 0);

    load("load_FFF", 16'h0FFF, 16'h0001);
    load("load_FFE", 16'h0FFE, 16'h0023);

    // SP wrap: pop to 0x000, push wraps to 0xFFF, pop back
    @(negedge clk); idle();
    mem_pop = 1;
    e = e0("wrap_pop0"); e.c_sp = 1; e.sp = 12'h000;
    go(e, 1, 0);
    @(negedge clk); idle();
    mem_push = 1; read_data1_in = 16'h1234;
    e = e0("wrap_push"); e.c_sp = 1; e.sp = 12'hFFF;
    go(e, 1, 0);
    @(negedge clk); idle();
    mem_pop = 1;
    e = e0("wrap_pop"); e.c_sp = 1; e.sp = 12'h000; e.c_md = 1; e.md = 16'h1234;
    go(e, 0, 0);
    load("load_000", 16'h0000, 16'h1234);

    // Priority: push beats pop and write
    store("store_030", 16'h0030, 16'hAAAA, 16'h1234);
    @(negedge clk); idle();
    mem_push = 1; mem_pop = 1; mem_write = 1; result_in = 16'h0030; read_data1_in = 16'h5555;
    e = e0("prio"); e.c_sp = 1; e.sp = 12'hFFF; e.c_md = 1; e.md = 16'h1234;
    go(e, 1, 0);
    load("prio_030", 16'h0030, 16'hAAAA);
    load("prio_000", 16'h0000, 16'h5555);

    // Same-cycle read and write returns the old word
    store("store_020", 16'h0020, 16'h1111, 16'h5555);
    @(negedge clk); idle();
    mem_read = 1; mem_write = 1; result_in = 16'h0020; read_data1_in = 16'h2222;
    e = e0("rbw"); e.c_md = 1; e.md = 16'h1111;
    go(e, 0, 0);
    load("rbw_after", 16'h0020, 16'h2222);

    // Flags source and Rsrc-addressed store
    @(negedge clk); idle();
    mem_write = 1; result_in = 16'h0040; memory_write_src_select = 2'b11; flag_register_in = 3'b101;
    e = e0("store_flags"); go(e, 0, 0);
    load("load_flags", 16'h0040, 16'h0005);
    @(negedge clk); idle();
    mem_write = 1; result_in = 16'h0060; memory_address_select = 2'b01;
    read_data2_in = 16'h0050; memory_write_src_select = 2'b01;
    e = e0("store_rsrc"); go(e, 0, 0);
    @(negedge clk); idle();
    mem_read = 1; memory_address_select = 2'b01; read_data2_in = 16'h0050;
    e = e0("load_rsrc"); e.c_md = 1; e.md = 16'h0050;
    go(e, 0, 0);

    // Reset in the middle of a wide push
    @(negedge clk); idle();
    mem_push = 1; memory_write_src_select = 2'b10; pc_plus_one_in = 32'hABCD_1234;
    result_in = 16'h7777; read_data1_in = 16'h6666; LDM_value = 16'h5555; input_port = 16'h4444;
    wb_sel = 2'b11; reg_write_address = 3'b111; outport_enable = 1; reg_write = 1;
    e = e0("abort_push1"); e.c_sp = 1; e.sp = 12'hFFE;
    go(e, 1, 1);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check_reset_outs("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    load("partial_FFF", 16'h0FFF, 16'hABCD);
    load("kept_010", 16'h0010, 16'hBEEF);

    repeat (2) @(negedge clk);
    chk("queues_drained", 128'(expq.size() + pcq.size()), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
